// File: rtl/memory_1r1w_fifo_ctrl.sv
// FIFO controller for an external 1R1W SRAM: writes pushes straight into memory and
// prefetches through the 1-cycle read port into a 2-entry output buffer.
module memory_1r1w_fifo_ctrl #(
    parameter int DATAW = 32,
    parameter int WORDW = 1024,
    parameter int ADDRW = $clog2(WORDW),
    localparam int CNTW = $clog2(WORDW + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [DATAW-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [DATAW-1:0] pop_data,
    output logic [CNTW-1:0]  count,
    output logic [ADDRW-1:0] mem_adra,
    output logic [DATAW-1:0] mem_da,
    output logic [DATAW-1:0] mem_wema,
    output logic             mem_wea,
    output logic             mem_mea,
    output logic [ADDRW-1:0] mem_adrb,
    output logic             mem_meb,
    input  logic [DATAW-1:0] mem_qb
);

    logic [ADDRW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0]  mem_count, mem_count_nxt, count_nxt;
    logic             inflight;
    logic [1:0]       buf_cnt, buf_cnt_nxt, pending, slot;
    logic [DATAW-1:0] buf_head, buf_tail, head_nxt, tail_nxt;
    logic             push_fire, pop_fire, rd_fire;

    function automatic logic [ADDRW-1:0] bump(input logic [ADDRW-1:0] p);
        return (p == ADDRW'(WORDW - 1)) ? '0 : p + ADDRW'(1);
    endfunction

    // mem_count only covers words written at earlier edges, so a read never races a write
    assign push_ready = (mem_count < CNTW'(WORDW)) & ~clear;
    assign push_fire  = push_valid & push_ready;
    assign pop_valid  = (buf_cnt != 2'd0);
    assign pop_fire   = pop_valid & pop_ready & ~clear;
    assign pending    = buf_cnt + 2'(inflight);
    assign rd_fire    = (mem_count != '0) & ((pending - 2'(pop_fire)) < 2'd2) & ~clear;

    assign mem_wea  = push_fire;
    assign mem_mea  = push_fire;
    assign mem_adra = wr_ptr;
    assign mem_da   = push_data;
    assign mem_wema = '1;
    assign mem_meb  = rd_fire;
    assign mem_adrb = rd_ptr;
    assign pop_data = buf_head;

    always_comb begin
        mem_count_nxt = mem_count + CNTW'(push_fire) - CNTW'(rd_fire);
        buf_cnt_nxt   = buf_cnt + 2'(inflight) - 2'(pop_fire);
        slot          = buf_cnt - 2'(pop_fire);
        head_nxt      = buf_head;
        tail_nxt      = buf_tail;
        // Head only shifts when a second word exists, so an emptied buffer keeps its last value
        if (pop_fire && buf_cnt == 2'd2) begin
            head_nxt = buf_tail;
        end
        if (inflight) begin
            if (slot == 2'd0) begin
                head_nxt = mem_qb;
            end else begin
                tail_nxt = mem_qb;
            end
        end
        count_nxt = mem_count_nxt + CNTW'(rd_fire) + CNTW'(buf_cnt_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            buf_cnt   <= 2'd0;
            buf_head  <= '0;
            buf_tail  <= '0;
            count     <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            buf_cnt   <= 2'd0;
            buf_head  <= '0;
            buf_tail  <= '0;
            count     <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= bump(rd_ptr);
            end
            mem_count <= mem_count_nxt;
            inflight  <= rd_fire;
            buf_cnt   <= buf_cnt_nxt;
            buf_head  <= head_nxt;
            buf_tail  <= tail_nxt;
            count     <= count_nxt;
        end
    end

endmodule

// File: tb/tb_memory_1r1w_fifo_ctrl.sv
// Bench for memory_1r1w_fifo_ctrl with a small non-power-of-two memory, an SRAM model
// and a queue-based scoreboard checking order, occupancy and addressing every cycle.
module tb_memory_1r1w_fifo_ctrl;

    localparam int DATAW = 16;
    localparam int WORDW = 5;
    localparam int ADDRW = 3;
    localparam int CNTW  = 3;

    logic             clk = 1'b0;
    logic             rst_n, clear, push_valid, push_ready, pop_valid, pop_ready;
    logic [DATAW-1:0] push_data, pop_data, mem_da, mem_wema, mem_qb;
    logic [CNTW-1:0]  count;
    logic [ADDRW-1:0] mem_adra, mem_adrb;
    logic             mem_wea, mem_mea, mem_meb;

    logic [DATAW-1:0] mem [0:7];
    logic [DATAW-1:0] model_q[$];
    int               wr_idx, rd_idx, pop_total;
    int               tests = 0;
    int               fails = 0;

    typedef struct {
        logic             pv;
        logic [DATAW-1:0] pd;
        logic             pr;
        logic [CNTW-1:0]  cnt;
        logic             valid;
        logic [DATAW-1:0] data;
        logic             wea;
        logic [ADDRW-1:0] adra;
    } vec_t;
    vec_t tbl [8];

    memory_1r1w_fifo_ctrl #(.DATAW(DATAW), .WORDW(WORDW), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .count(count),
        .mem_adra(mem_adra), .mem_da(mem_da), .mem_wema(mem_wema), .mem_wea(mem_wea),
        .mem_mea(mem_mea), .mem_adrb(mem_adrb), .mem_meb(mem_meb), .mem_qb(mem_qb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_mea && mem_wea) mem[mem_adra] <= mem_da;
        if (mem_meb) mem_qb <= mem[mem_adrb];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic pv, input logic [DATAW-1:0] pd, input logic pr, input logic clr);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        clear      = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_output({pfx, "_push_ready"}, 32'(push_ready), 1);
        check_output({pfx, "_pop_valid"}, 32'(pop_valid), 0);
        check_output({pfx, "_pop_data"}, 32'(pop_data), 0);
        check_output({pfx, "_count"}, 32'(count), 0);
        check_output({pfx, "_wea_mea_meb"}, {29'd0, mem_wea, mem_mea, mem_meb}, 0);
        check_output({pfx, "_addrs"}, {26'd0, mem_adra, mem_adrb}, 0);
    endtask

    task automatic drain(input string name);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (count == '0) break;
            tick();
        end
        check_output(name, 32'(count), 0);
        tick();
        pop_ready = 1'b0;
    endtask

    task automatic wait_pop_valid(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pop_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_output(name, 32'(found), 1);
    endtask

    // Scoreboard: the FIFO is just an ordered queue; the i-th write/read targets address i mod WORDW
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            wr_idx = 0;
            rd_idx = 0;
        end else begin
            check_output("mon_count", 32'(count), 32'(model_q.size()));
            check_output("mon_wema", 32'(mem_wema), 32'hFFFF);
            if (model_q.size() == 0) check_output("mon_empty_pop_valid", 32'(pop_valid), 0);
            if (clear) begin
                check_output("mon_clear_ports", {29'd0, mem_wea, mem_mea, mem_meb}, 0);
                model_q.delete();
                wr_idx = 0;
                rd_idx = 0;
            end else begin
                if (model_q.size() < WORDW) check_output("mon_push_ready", 32'(push_ready), 1);
                if (model_q.size() == WORDW + 2) check_output("mon_full_push_ready", 32'(push_ready), 0);
                if (mem_meb) begin
                    check_output("mon_adrb", 32'(mem_adrb), 32'(rd_idx % WORDW));
                    rd_idx++;
                end
                if (pop_valid && pop_ready) begin
                    tests++;
                    if (model_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL mon_pop_underflow: got pop of 0x%0h, expected no data", pop_data);
                    end else begin
                        if (pop_data !== model_q[0]) begin
                            fails++;
                            $display("[TB] FAIL mon_pop_data: got 0x%0h, expected 0x%0h", pop_data, model_q[0]);
                        end
                        void'(model_q.pop_front());
                    end
                    pop_total++;
                end
                if (push_valid && push_ready) begin
                    check_output("mon_wea_mea", {30'd0, mem_wea, mem_mea}, 3);
                    check_output("mon_adra", 32'(mem_adra), 32'(wr_idx % WORDW));
                    model_q.push_back(push_data);
                    wr_idx++;
                end else begin
                    check_output("mon_idle_wea", {30'd0, mem_wea, mem_mea}, 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted, pushed, popped;
        bit found;
        //          pv    pd      pr    cnt   valid data    wea   adra
        tbl[0] = '{1'b1, 16'h11, 1'b0, 3'd0, 1'b0, 16'h00, 1'b1, 3'd0};
        tbl[1] = '{1'b1, 16'h22, 1'b0, 3'd1, 1'b0, 16'h00, 1'b1, 3'd1};
        tbl[2] = '{1'b1, 16'h33, 1'b0, 3'd2, 1'b0, 16'h00, 1'b1, 3'd2};
        tbl[3] = '{1'b0, 16'h00, 1'b0, 3'd3, 1'b1, 16'h11, 1'b0, 3'd3};
        tbl[4] = '{1'b0, 16'h00, 1'b1, 3'd3, 1'b1, 16'h11, 1'b0, 3'd3};
        tbl[5] = '{1'b0, 16'h00, 1'b1, 3'd2, 1'b1, 16'h22, 1'b0, 3'd3};
        tbl[6] = '{1'b0, 16'h00, 1'b1, 3'd1, 1'b1, 16'h33, 1'b0, 3'd3};
        tbl[7] = '{1'b0, 16'h00, 1'b0, 3'd0, 1'b0, 16'h33, 1'b0, 3'd3};

        rst_n = 1'b0;
        pop_total = 0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tbl[i].pv, tbl[i].pd, tbl[i].pr, 1'b0);
            @(negedge clk);
            check_output($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check_output($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(tbl[i].valid));
            check_output($sformatf("vec%0d_pop_data", i), 32'(pop_data), 32'(tbl[i].data));
            check_output($sformatf("vec%0d_wea", i), 32'(mem_wea), 32'(tbl[i].wea));
            check_output($sformatf("vec%0d_adra", i), 32'(mem_adra), 32'(tbl[i].adra));
            tick();
        end

        // Fill without popping: memory plus both buffer slots
        accepted = 0;
        apply_stimulus(1'b1, 16'h200, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!push_ready) break;
            accepted++;
            tick();
            push_data = 16'(16'h200 + accepted);
        end
        check_output("full_accepted", 32'(accepted), WORDW + 2);
        check_output("full_count", 32'(count), WORDW + 2);
        check_output("full_pop_valid", 32'(pop_valid), 1);
        tick();
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        pop_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (push_ready) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_output("full_ready_returns", 32'(found), 1);
        tick();
        drain("full_drain");

        // Streaming push and pop together, wrapping both pointers
        pushed = 0;
        popped = 0;
        for (int k = 0; k < 40 && popped < 13; k++) begin
            apply_stimulus(pushed < 13, 16'(16'h100 + pushed), 1'b1, 1'b0);
            @(negedge clk);
            if (push_valid && push_ready) pushed++;
            if (popped > 0) check_output("stream_no_bubble", 32'(pop_valid), 1);
            if (pop_valid) popped++;
            tick();
        end
        check_output("stream_popped", 32'(popped), 13);
        drain("stream_drain");

        // Continuous incrementing pushes against a random consumer
        pushed = 0;
        pop_total = 0;
        for (int k = 0; k < 8000 && pushed < 1000; k++) begin
            apply_stimulus(1'b1, 16'(pushed), 1'($urandom_range(0, 1)), 1'b0);
            @(negedge clk);
            if (push_ready) pushed++;
            tick();
        end
        check_output("random_pushed", 32'(pushed), 1000);
        drain("random_drain");
        check_output("random_pop_total", 32'(pop_total), 1000);

        // Clear while one word is buffered and another is in flight
        apply_stimulus(1'b1, 16'h0A1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 16'h0B2, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 16'h0C3, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 16'h0D4, 1'b1, 1'b1);
        @(negedge clk);
        check_output("clear_setup_count", 32'(count), 3);
        check_output("clear_setup_head", 32'(pop_data), 16'h0A1);
        check_output("clear_push_ready", 32'(push_ready), 0);
        check_output("clear_ports", {29'd0, mem_wea, mem_mea, mem_meb}, 0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("clear_count", 32'(count), 0);
        check_output("clear_pop_valid", 32'(pop_valid), 0);
        tick();
        tick();
        apply_stimulus(1'b1, 16'h0AA, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        wait_pop_valid("clear_aa_valid");
        check_output("clear_aa_data", 32'(pop_data), 16'h0AA);
        check_output("clear_aa_count", 32'(count), 1);
        tick();
        drain("clear_drain");

        // Asynchronous reset in the middle of a stream
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 16'(16'h300 + k), 1'b1, 1'b0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 16'h005, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        wait_pop_valid("midreset_valid");
        check_output("midreset_count", 32'(count), 1);
        check_output("midreset_data", 32'(pop_data), 16'h005);
        tick();
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        @(negedge clk);
        check_output("midreset_final_count", 32'(count), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
